// File: rtl/weight_bit_sequencer.sv
// Serializes M latched two's-complement weights into Pw bit planes, LSB first,
// framed by a clear pulse before the planes and a done pulse after the last one.
module weight_bit_sequencer #(
  parameter int unsigned M  = 16,
  parameter int unsigned Pw = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [M*Pw-1:0] w_in,
  input  logic            abort,
  output logic            cl_en,
  output logic            w_en,
  output logic            MSB_w,
  output logic [M-1:0]    w_bits,
  output logic            done
);

  localparam int unsigned BW = (Pw > 1) ? $clog2(Pw) : 1;
  localparam logic [BW-1:0] BLast = BW'(Pw - 1);

  typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     b_q, b_d;
  logic [M*Pw-1:0]   latch_q, latch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      b_q     <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      latch_q <= latch_d;
    end
  end

  // Abort outranks acceptance and cancels from any busy state.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    latch_d = latch_q;
    case (state_q)
      StIdle: begin
        if (start_valid && !abort) begin
          state_d = StClear;
          latch_d = w_in;
        end
      end
      StClear: begin
        b_d     = '0;
        state_d = abort ? StIdle : StShift;
      end
      StShift: begin
        if (abort) begin
          state_d = StIdle;
          b_d     = '0;
        end else if (b_q == BLast) begin
          state_d = StDone;
          b_d     = '0;
        end else begin
          b_d = b_q + BW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        b_d     = '0;
      end
    endcase
  end

  // Outputs depend only on registered state, counter and latch.
  always_comb begin
    logic [Pw-1:0] wt;
    wt          = '0;
    start_ready = (state_q == StIdle);
    cl_en       = (state_q == StClear);
    w_en        = (state_q == StShift);
    MSB_w       = (state_q == StShift) && (b_q == BLast);
    done        = (state_q == StDone);
    w_bits      = '0;
    if (state_q == StShift) begin
      for (int j = 0; j < int'(M); j++) begin
        wt        = latch_q[j*Pw +: Pw];
        w_bits[j] = wt[b_q];
      end
    end
  end

endmodule

// File: tb/tb_weight_bit_sequencer.sv
// Directed bench for weight_bit_sequencer (M=16, Pw=8) using immediate assertions.
module tb_weight_bit_sequencer;

  localparam int unsigned M  = 16;
  localparam int unsigned Pw = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_valid;
  logic            start_ready;
  logic [M*Pw-1:0] w_in;
  logic            abort;
  logic            cl_en;
  logic            w_en;
  logic            MSB_w;
  logic [M-1:0]    w_bits;
  logic            done;

  int n_pass  = 0;
  int n_total = 0;

  weight_bit_sequencer #(
    .M  (M),
    .Pw (Pw)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .w_in        (w_in),
    .abort       (abort),
    .cl_en       (cl_en),
    .w_en        (w_en),
    .MSB_w       (MSB_w),
    .w_bits      (w_bits),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs {start_ready, cl_en, w_en, MSB_w, done} for compact idle checks.
  function automatic logic [4:0] ctl();
    return {start_ready, cl_en, w_en, MSB_w, done};
  endfunction

  function automatic logic [M-1:0] plane(input logic [M*Pw-1:0] v, input int b);
    logic [M-1:0] r;
    for (int j = 0; j < int'(M); j++) r[j] = v[j*Pw + b];
    return r;
  endfunction

  logic [M-1:0]    a5_planes [8];
  logic [M*Pw-1:0] v;
  int              cl_cyc [$];
  int              hits;

  initial begin
    a5_planes = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                  16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    rst_n = 1'b0; start_valid = 1'b0; abort = 1'b0; w_in = '0;
    #2;
    chk("reset_ctl", 32'(ctl()), 32'b10000);
    chk("reset_bits", 32'(w_bits), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ctl", 32'(ctl()), 32'b10000);

    // All weights 8'hA5.
    w_in = {M{8'hA5}};
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("a5_clear", 32'(ctl()), 32'b01000);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("a5_wen%0d", i), 32'(w_en), 32'h1);
      chk($sformatf("a5_msb%0d", i), 32'(MSB_w), (i == 7) ? 32'h1 : 32'h0);
      chk($sformatf("a5_bits%0d", i), 32'(w_bits), 32'(a5_planes[i]));
    end
    tick();
    chk("a5_done", 32'(ctl()), 32'b00001);
    tick();
    chk("a5_ready", 32'(ctl()), 32'b10000);

    // Only weight 0 = 8'h80: sign bit appears in the last plane only.
    w_in = '0;
    w_in[7:0] = 8'h80;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    w_in = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("w80_bits%0d", i), 32'(w_bits), (i == 7) ? 32'h1 : 32'h0);
    end
    chk("w80_msb", 32'(MSB_w), 32'h1);
    tick();
    chk("w80_done", 32'(done), 32'h1);
    tick();

    // start_valid held high: accepts every 11 cycles, cl_en never with w_en.
    w_in = {M{8'h3C}};
    start_valid = 1'b1;
    hits = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (cl_en) cl_cyc.push_back(c);
      if (cl_en && w_en) hits++;
    end
    start_valid = 1'b0;
    chk("hold_overlap", 32'(hits), 32'h0);
    chk("hold_count", 32'(cl_cyc.size()), 32'd3);
    if (cl_cyc.size() == 3) begin
      chk("hold_gap1", 32'(cl_cyc[1] - cl_cyc[0]), 32'd11);
      chk("hold_gap2", 32'(cl_cyc[2] - cl_cyc[1]), 32'd11);
    end
    hits = 0;
    for (int c = 0; c < 20 && !start_ready; c++) tick();
    chk("hold_drain", 32'(start_ready), 32'h1);

    // Abort in the 3rd w_en cycle.
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick(); tick();
    chk("abort_in_shift", 32'(w_en), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ctl", 32'(ctl()), 32'b10000);
    chk("abort_bits", 32'(w_bits), 32'h0);
    tick();
    chk("abort_nodone", 32'(ctl()), 32'b10000);

    // Abort beats acceptance in idle.
    abort = 1'b1; start_valid = 1'b1;
    tick();
    abort = 1'b0; start_valid = 1'b0;
    chk("abort_idle", 32'(ctl()), 32'b10000);

    // Reset in the 5th w_en cycle.
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_in_shift", 32'(w_en), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", 32'(ctl()), 32'b10000);
    chk("rst_async_bits", 32'(w_bits), 32'h0);
    tick();
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || !start_ready) hits++;
    end
    chk("rst_release_idle", 32'(hits), 32'h0);

    // Accept on first edge after reset release, then scramble w_in each cycle.
    #2 rst_n = 1'b0;
    v = {$urandom, $urandom, $urandom, $urandom};
    w_in = v;
    start_valid = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("post_rst_accept", 32'(cl_en), 32'h1);
    for (int i = 0; i < 8; i++) begin
      w_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk($sformatf("rnd_bits%0d", i), 32'(w_bits), 32'(plane(v, i)));
    end
    tick();
    chk("rnd_done", 32'(done), 32'h1);
    tick();
    chk("rnd_ready", 32'(ctl()), 32'b10000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
